// File: rtl/decoder_rr_arbiter_pkg.sv
// rtl/decoder_rr_arbiter_pkg.sv - shared states, defaults and helpers for the decoder arbiter
package decoder_rr_arbiter_pkg;

  // FSM encodings: idle arbitration, active ownership, one dead cycle between owners
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_HOLD_MAX = 15;
  localparam int DEF_CNT_W    = 4;

  // Index to one-hot grant, mirroring what the 2-to-4 decoder produces for that index
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// rtl/decoder_rr_arbiter_rr_pick.sv - rotated-priority search over four requesters
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any_req
);

  // Walk from the farthest candidate back to ptr so the nearest set bit wins
  always_comb begin
    logic [1:0] cand;
    idx     = ptr;
    any_req = |req;
    cand    = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin owner sequencer for the shared 2-to-4 decoder
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] req,
  output logic       sel_1,
  output logic       sel_2,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  // Value of hold_cnt on the last cycle an owner may keep the decoder
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] hold_cnt, cnt_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       owner, owner_nx;
  logic [3:0]       grant_nx;
  logic             valid_nx;
  logic             timeout_nx;
  logic [1:0]       pick_idx;
  logic             pick_any;

  // The decoder select lines are the owner index; they keep the last owner while idle
  assign sel_1 = owner[1];
  assign sel_2 = owner[0];

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // Next-state and next-output decisions; everything holds unless a transition says otherwise
  always_comb begin
    state_nx   = state;
    cnt_nx     = hold_cnt;
    ptr_nx     = ptr;
    owner_nx   = owner;
    grant_nx   = grant;
    valid_nx   = grant_valid;
    timeout_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx = ST_GRANT;
          owner_nx = pick_idx;
          grant_nx = onehot4(pick_idx);
          valid_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        // A voluntary release outranks the hold limit, so it never raises timeout
        if (!req[owner]) begin
          state_nx = ST_GAP;
          grant_nx = 4'b0000;
          valid_nx = 1'b0;
          ptr_nx   = owner + 2'd1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx   = ST_GAP;
          grant_nx   = 4'b0000;
          valid_nx   = 1'b0;
          ptr_nx     = owner + 2'd1;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = 4'b0000;
        valid_nx = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; reset wins over any pending revoke
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      ptr         <= 2'd0;
      owner       <= 2'd0;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= cnt_nx;
      ptr         <= ptr_nx;
      owner       <= owner_nx;
      grant       <= grant_nx;
      grant_valid <= valid_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - self-checking bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

  localparam int NI = 4;
  localparam int HM_TAB [NI] = '{15, 4, 2, 1};

  logic       clk;
  logic       sys_rst;
  logic [3:0] req;
  logic [3:0] grant_o [NI];
  logic       sel1_o  [NI];
  logic       sel2_o  [NI];
  logic       gv_o    [NI];
  logic       to_o    [NI];

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 when none), completed grant cycles, gap cycles still to wait
  int m_owner [NI];
  int m_held  [NI];
  int m_wait  [NI];
  int m_prio  [NI];
  int m_sel   [NI];
  int m_tout  [NI];

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    bit         tout;
  } vec_t;

  vec_t tbl [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    decoder_rr_arbiter #(.HOLD_MAX(HM_TAB[g]), .CNT_W(4)) u_dut (
      .sys_clk     (clk),
      .sys_rst     (sys_rst),
      .req         (req),
      .sel_1       (sel1_o[g]),
      .sel_2       (sel2_o[g]),
      .grant       (grant_o[g]),
      .grant_valid (gv_o[g]),
      .timeout     (to_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input logic [3:0] r);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_owner[k] = -1; m_held[k] = 0; m_wait[k] = 0;
        m_prio[k] = 0; m_sel[k] = 0; m_tout[k] = 0;
      end else begin
        m_tout[k] = 0;
        if (m_owner[k] >= 0) begin
          m_held[k]++;
          if (!r[m_owner[k]] || m_held[k] == HM_TAB[k]) begin
            m_tout[k]  = r[m_owner[k]] ? 1 : 0;
            m_prio[k]  = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_wait[k]  = 1;
          end
        end else if (m_wait[k] > 0) begin
          m_wait[k]--;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (m_owner[k] < 0 && r[(m_prio[k] + i) % 4]) begin
              m_owner[k] = (m_prio[k] + i) % 4;
              m_held[k]  = 0;
              m_sel[k]   = m_owner[k];
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      int eg;
      eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
      chk($sformatf("%s hm%0d grant", tag, HM_TAB[k]), int'(grant_o[k]), eg);
      chk($sformatf("%s hm%0d valid", tag, HM_TAB[k]), int'(gv_o[k]), (eg != 0) ? 1 : 0);
      chk($sformatf("%s hm%0d sel", tag, HM_TAB[k]), int'({sel1_o[k], sel2_o[k]}), m_sel[k]);
      chk($sformatf("%s hm%0d timeout", tag, HM_TAB[k]), int'(to_o[k]), m_tout[k]);
      chk($sformatf("%s hm%0d onehot", tag, HM_TAB[k]), ($countones(grant_o[k]) <= 1) ? 1 : 0, 1);
    end
  endtask

  task automatic cycle(input bit rst, input logic [3:0] r, input string tag);
    sys_rst = rst;
    req     = r;
    @(posedge clk);
    model_step(rst, r);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic add(input bit rst, input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] s, input bit t);
    vec_t v;
    v.rst = rst; v.req = r; v.grant = g; v.sel = s; v.tout = t;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt;
    int tseen;
    logic [3:0] r;
    logic [3:0] mask;

    sys_rst = 1'b1;
    req     = 4'b0000;
    model_step(1'b1, 4'b0000);
    @(negedge clk);

    // Reset with all requesting, then a full HOLD_MAX=4 rotation (expectations for hm4 instance)
    for (int i = 0; i < 3; i++) add(1, 4'b1111, 4'b0000, 2'b00, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0001, 2'b00, 0);
    add(0, 4'b1111, 4'b0000, 2'b00, 1);
    add(0, 4'b1111, 4'b0000, 2'b00, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0010, 2'b01, 0);
    add(0, 4'b1111, 4'b0000, 2'b01, 1);
    add(0, 4'b1111, 4'b0000, 2'b01, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b0100, 2'b10, 0);
    add(0, 4'b1111, 4'b0000, 2'b10, 1);
    add(0, 4'b1111, 4'b0000, 2'b10, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1111, 4'b1000, 2'b11, 0);
    add(0, 4'b1111, 4'b0000, 2'b11, 1);
    add(0, 4'b1111, 4'b0000, 2'b11, 0);
    add(0, 4'b1111, 4'b0001, 2'b00, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].req, "table");
      chk($sformatf("tbl%0d grant", i), int'(grant_o[1]), int'(tbl[i].grant));
      chk($sformatf("tbl%0d sel", i), int'({sel1_o[1], sel2_o[1]}), int'(tbl[i].sel));
      chk($sformatf("tbl%0d timeout", i), int'(to_o[1]), int'(tbl[i].tout));
    end

    // Release: a 6-cycle request on the hm15 instance gives exactly 6 grant cycles, no timeout
    for (int i = 0; i < 4; i++) cycle(0, 4'b0000, "idle1");
    cnt = 0; tseen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 4'b0100, "release");
      if (grant_o[0] == 4'b0100 && {sel1_o[0], sel2_o[0]} == 2'b10) cnt++;
      if (to_o[0]) tseen++;
    end
    cycle(0, 4'b0000, "release");
    chk("release grant cycles", cnt, 6);
    chk("release grant after drop", int'(grant_o[0]), 0);
    chk("release timeout seen", tseen + int'(to_o[0]), 0);

    // Release coincides with the hold limit on the hm4 instance: no timeout, ptr moves to 3
    for (int i = 0; i < 3; i++) cycle(0, 4'b0000, "idle2");
    for (int i = 0; i < 4; i++) begin
      cycle(0, 4'b0100, "simul");
      chk($sformatf("simul grant c%0d", i), int'(grant_o[1]), 4);
    end
    cycle(0, 4'b0000, "simul");
    chk("simul grant dropped", int'(grant_o[1]), 0);
    chk("simul no timeout", int'(to_o[1]), 0);
    cycle(0, 4'b1111, "simul");
    cycle(0, 4'b1111, "simul");
    chk("simul next owner is 3", int'(grant_o[1]), 8);

    // Sole requester on the hm2 instance: two on, timeout gap, idle, repeat
    for (int i = 0; i < 6; i++) cycle(0, 4'b0000, "idle3");
    for (int i = 0; i < 16; i++) begin
      cycle(0, 4'b0010, "sole");
      chk($sformatf("sole grant c%0d", i), int'(grant_o[2]), ((i % 4) < 2) ? 2 : 0);
      chk($sformatf("sole timeout c%0d", i), int'(to_o[2]), ((i % 4) == 2) ? 1 : 0);
      chk($sformatf("sole sel c%0d", i), int'({sel1_o[2], sel2_o[2]}), 1);
    end

    // Reset while requester 3 owns the hm15 instance
    for (int i = 0; i < 6; i++) cycle(0, 4'b0000, "idle4");
    cnt = 0;
    while (grant_o[0] != 4'b1000 && cnt < 10) begin
      cycle(0, 4'b1000, "midrst");
      cnt++;
    end
    chk("midrst grant reached", int'(grant_o[0]), 8);
    cycle(1, 4'b1001, "midrst");
    chk("midrst grant cleared", int'(grant_o[0]), 0);
    chk("midrst no timeout", int'(to_o[0]), 0);
    cycle(0, 4'b1001, "midrst");
    chk("midrst first after reset", int'(grant_o[0]), 1);

    // Randomized sticky requests with rare resets against the model
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      mask = '0;
      for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 3) == 0);
      r = r ^ mask;
      cycle(($urandom_range(0, 199) == 0), r, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
